lsu: RTL and testbench
======================

LSU -- requirements
Module: lsu

Interface
REQ-001 Parameters: none; the memory-side word address is full 32 bits.
REQ-002 clk  input  1  single clock; all state changes on posedge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req_valid  input  1  core presents a load/store request.
REQ-005 req_ready  output  1  LSU can accept a request this cycle.
REQ-006 req_write  input  1  1=store, 0=load.
REQ-007 req_funct3  input  3  RV32I funct3 for the access (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data; byte/half in low bits.
REQ-010 resp_valid  output  1  one-cycle pulse marking completion.
REQ-011 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-012 resp_err  output  1  with resp_valid: misaligned address or illegal funct3.
REQ-013 mem_read  output  1  word read strobe to the data memory.
REQ-014 mem_write  output  1  word write strobe; memory writes on the posedge.
REQ-015 mem_addr  output  32  word-aligned byte address {addr[31:2],2'b00}.
REQ-016 mem_wdata  output  32  full word to write.
REQ-017 mem_rdata  input  32  combinational read data, valid in the same cycle as mem_read.

Function
REQ-018 FSM states: IDLE, LOAD, RMW_RD, STORE, RESP.
REQ-019 req_ready SHALL be 1 only in IDLE with rst low.
REQ-020 On req_valid&&req_ready, latch write, funct3, addr and wdata; later req_* changes have no effect.
REQ-021 Illegal funct3 SHALL go to RESP with resp_err=1:
- loads: 011, 110, 111
- stores: any funct3 other than 000/001/010
REQ-022 Misaligned accesses SHALL go to RESP with resp_err=1 and no memory strobe:
- half with addr[0]=1
- word with addr[1:0]!=00
REQ-023 Legal load: IDLE->LOAD; LOAD asserts mem_read, captures the extended mem_rdata, then goes to RESP.
REQ-024 Legal SW: IDLE->STORE; STORE asserts mem_write with mem_wdata=wdata, then goes to RESP.
REQ-025 Legal SB/SH: IDLE->RMW_RD->STORE->RESP.
- RMW_RD asserts mem_read and captures mem_rdata.
- STORE writes the captured word with the lane(s) selected by addr[1:0] replaced by wdata[7:0] or wdata[15:0].
- All other bytes are unchanged.
REQ-026 Load extraction selects the byte lane by addr[1:0] and the half lane by addr[1].
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word through.
REQ-027 RESP asserts resp_valid for exactly one cycle, then returns to IDLE; there is no response backpressure.
REQ-028 Latency from the accept edge to resp_valid high:
- 2 cycles for loads and SW
- 3 cycles for SB/SH
- 1 cycle for errors
REQ-029 mem_read and mem_write SHALL never both be 1, and both are 0 outside the LOAD, RMW_RD and STORE states.
REQ-030 resp_rdata holds its value until the next response; it is 0 for stores and errors.
REQ-031 At most one request is outstanding; back-to-back requests are accepted at the earliest in the IDLE cycle after RESP.

Reset
REQ-032 While rst=1:
- state is forced to IDLE
- mem_read, mem_write, req_ready and resp_valid are 0
- resp_rdata and resp_err are 0
REQ-033 Reset mid-operation aborts the access with no response; mem_write is suppressed combinationally when rst=1, so an interrupted store SHALL NOT write.
REQ-034 In the first cycle after rst deasserts, req_ready=1.

Verification
REQ-035 Memory word 0x10 = 0x8899AABB; LB at 0x12 -> one mem_read at 0x10, resp_rdata=0xFFFFFF99 two cycles after accept; LBU at the same address -> 0x00000099.
REQ-036 Memory word 0x20 = 0x11223344; SB 0xA5 at 0x21 -> RMW_RD read, then a single mem_write of 0x1122A544 at 0x20; resp_valid 3 cycles after accept; resp_err=0.
REQ-037 SH 0xBEEF at 0x22 over 0x00000000 -> mem_wdata=0xBEEF0000; then LH at 0x22 -> 0xFFFFBEEF, LHU at 0x22 -> 0x0000BEEF.
REQ-038 LW at 0x06 and SH at 0x03 -> resp_err=1 one cycle after accept, with no mem_read or mem_write strobe in between.
REQ-039 SW started, rst asserted in the STORE cycle -> mem_write stays 0, memory is unchanged, resp_valid is never asserted, and req_ready=1 the cycle after rst drops.
REQ-040 Back-to-back SW 0xDEADBEEF at 0x40 then LW at 0x40, with req_valid held high -> second accept in the IDLE cycle after RESP; LW returns 0xDEADBEEF.

Source files
------------

// File: rtl/lsu.sv
// ============================================================================
// lsu : single-outstanding RV32I load/store unit with byte/half RMW stores
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_RMW_RD = 3'd2;
  localparam logic [2:0] S_STORE  = 3'd3;
  localparam logic [2:0] S_RESP   = 3'd4;

  logic [2:0]  state;
  logic [2:0]  next_state;
  logic        r_write;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_word;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_illegal;
  logic        w_misaligned;
  logic        w_req_err;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_merged;

  assign w_accept = req_valid && req_ready;

  // Request classification is done on the live request so the accept edge
  // can branch straight to the right state.
  always_comb begin
    w_illegal    = 1'b0;
    w_misaligned = 1'b0;
    if (req_write)
      w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    else
      w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                   ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
    w_req_err = w_illegal || w_misaligned;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_req_err)                      next_state = S_RESP;
          else if (!req_write)                next_state = S_LOAD;
          else if (req_funct3[1:0] == 2'b10)  next_state = S_STORE;
          else                                next_state = S_RMW_RD;
        end
      end
      S_LOAD:   next_state = S_RESP;
      S_RMW_RD: next_state = S_STORE;
      S_STORE:  next_state = S_RESP;
      S_RESP:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Strobes are gated by rst so a store interrupted by reset never writes.
  always_comb begin
    req_ready  = !rst && (state == S_IDLE);
    resp_valid = !rst && (state == S_RESP);
    resp_err   = resp_valid && r_err;
    resp_rdata = rst ? 32'd0 : r_rdata;
    mem_read   = !rst && ((state == S_LOAD) || (state == S_RMW_RD));
    mem_write  = !rst && (state == S_STORE);
    mem_addr   = {r_addr[31:2], 2'b00};
    mem_wdata  = (r_funct3[1:0] == 2'b10) ? r_wdata : w_merged;
  end

  always_comb begin
    case (r_addr[1:0])
      2'b00:   w_byte = mem_rdata[7:0];
      2'b01:   w_byte = mem_rdata[15:8];
      2'b10:   w_byte = mem_rdata[23:16];
      default: w_byte = mem_rdata[31:24];
    endcase
    w_half = r_addr[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = mem_rdata;
    endcase
  end

  always_comb begin
    w_merged = r_word;
    if (r_funct3[1:0] == 2'b00)
      w_merged[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
    else
      w_merged[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write  <= 1'b0;
      r_funct3 <= 3'd0;
      r_addr   <= 32'd0;
      r_wdata  <= 32'd0;
      r_word   <= 32'd0;
      r_rdata  <= 32'd0;
      r_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_funct3 <= req_funct3;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_err    <= w_req_err;
      end
      if (state == S_RMW_RD)
        r_word <= mem_rdata;
      // Response data changes only on the edge that enters RESP.
      if (state == S_LOAD)
        r_rdata <= w_load;
      else if ((state == S_STORE) || (w_accept && w_req_err))
        r_rdata <= 32'd0;
    end
  end

  logic unused_ok;
  assign unused_ok = r_write;

endmodule

`default_nettype wire

// File: tb/tb_lsu.sv
// ============================================================================
// tb_lsu : randomized self-checking bench for lsu against a byte-level model
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_lsu;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  lsu dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Environment memory: 256 words, combinational read, posedge write.
  logic [31:0] mem [0:255];
  logic        pl_en;
  logic [7:0]  pl_addr;
  logic [31:0] pl_data;

  assign mem_rdata = mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr] <= pl_data;
    else if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
  end

  // Reference model: flat byte-addressed memory.
  logic [7:0]  ref_mem [0:1023];
  int          n_err;
  int          n_chk;
  logic [31:0] last_rdata;
  logic        last_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_word(input int a);
    int b;
    b = a & 1020;
    return {ref_mem[b+3], ref_mem[b+2], ref_mem[b+1], ref_mem[b]};
  endfunction

  function automatic bit ref_err(input bit wr, input logic [2:0] f3, input logic [31:0] a);
    int size;
    if (wr) begin
      if (f3 > 3'd2) return 1'b1;
      size = int'(f3);
    end else begin
      if (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7) return 1'b1;
      size = int'(f3) % 4;
    end
    if (size == 1 && (a % 2) != 0) return 1'b1;
    if (size == 2 && (a % 4) != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int          i;
    logic [31:0] v;
    i = int'(a) & 1023;
    v = {ref_mem[(i+3)&1023], ref_mem[(i+2)&1023], ref_mem[(i+1)&1023], ref_mem[i]};
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    int          n;
    logic [31:0] d;
    n = 1 << f3[1:0];
    d = wd;
    for (int i = 0; i < n; i++) begin
      ref_mem[(int'(a) + i) & 1023] = d[7:0];
      d = d >> 8;
    end
  endtask

  task automatic preload(input int a, input logic [31:0] v);
    @(negedge clk);
    pl_en   = 1'b1;
    pl_addr = a[9:2];
    pl_data = v;
    ref_store(3'd2, a & 1020, v);
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic wait_ready();
    int c;
    c = 0;
    while (!req_ready && c < 10) begin
      @(negedge clk);
      c++;
    end
    check("req_ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  // One full transaction: drive, scramble inputs after accept, watch strobes.
  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    bit          e;
    int          exp_lat, exp_rd, exp_wr, cyc, nrd, nwr;
    logic [31:0] exp_data;
    e        = ref_err(wr, f3, a);
    exp_data = (!e && !wr) ? ref_load(f3, a) : 32'd0;
    exp_rd   = (!e && (!wr || f3 != 3'd2)) ? 1 : 0;
    exp_wr   = (!e && wr) ? 1 : 0;
    exp_lat  = e ? 1 : ((wr && f3 != 3'd2) ? 3 : 2);
    wait_ready();
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    req_write  = 1'($urandom);
    req_funct3 = 3'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
    cyc = 0; nrd = 0; nwr = 0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      nrd += int'(mem_read);
      nwr += int'(mem_write);
      check("strobe_excl", {31'd0, mem_read & mem_write}, 32'd0);
      if (mem_read || mem_write)
        check("mem_addr", mem_addr, {a[31:2], 2'b00});
      if (resp_valid) break;
    end
    if (!e && wr) ref_store(f3, a, wd);
    last_rdata = resp_rdata;
    last_err   = resp_err;
    check("resp_valid", {31'd0, resp_valid}, 32'd1);
    check("latency", cyc, exp_lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, e});
    check("resp_rdata", resp_rdata, exp_data);
    check("n_reads", nrd, exp_rd);
    check("n_writes", nwr, exp_wr);
    if (wr) check("mem_word", mem[a[9:2]], ref_word(int'(a)));
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("rdata_hold", resp_rdata, exp_data);
  endtask

  task automatic reset_mid_store();
    int seen;
    preload(32'h30, 32'h12345678);
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mem_write", {31'd0, mem_write}, 32'd0);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_after_rst", {31'd0, req_ready}, 32'd1);
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    check("no_resp_after_rst", seen, 0);
    check("mem_unchanged", mem[8'h0C], 32'h12345678);
  endtask

  task automatic back_to_back();
    wait_ready();
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2;
    req_addr = 32'h40; req_wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    req_write = 1'b0; req_funct3 = 3'd2; req_wdata = $urandom;
    ref_store(3'd2, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    check("b2b_ready_store", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_resp1", {31'd0, resp_valid}, 32'd1);
    check("b2b_ready_resp", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    check("b2b_ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("b2b_load_read", {31'd0, mem_read}, 32'd1);
    @(negedge clk);
    check("b2b_resp2", {31'd0, resp_valid}, 32'd1);
    check("b2b_lw_data", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_err = 0; n_chk = 0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    pl_en = 1'b0; pl_addr = 8'd0; pl_data = 32'd0;
    for (int w = 0; w < 256; w++) preload(w * 4, $urandom);
    @(negedge clk);
    check("reset_req_ready", {31'd0, req_ready}, 32'd0);
    check("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("reset_strobes", {30'd0, mem_read, mem_write}, 32'd0);
    check("reset_rdata", resp_rdata, 32'd0);
    check("reset_err", {31'd0, resp_err}, 32'd0);
    rst = 1'b0;
    #1 check("ready_first_cycle", {31'd0, req_ready}, 32'd1);
    @(negedge clk);

    preload(32'h10, 32'h8899AABB);
    do_req(1'b0, 3'd0, 32'h12, 32'd0);
    check("lb_0x12", last_rdata, 32'hFFFFFF99);
    do_req(1'b0, 3'd4, 32'h12, 32'd0);
    check("lbu_0x12", last_rdata, 32'h00000099);

    preload(32'h20, 32'h11223344);
    do_req(1'b1, 3'd0, 32'h21, 32'h000000A5);
    check("sb_word", mem[8'h08], 32'h1122A544);

    preload(32'h20, 32'h00000000);
    do_req(1'b1, 3'd1, 32'h22, 32'h0000BEEF);
    check("sh_word", mem[8'h08], 32'hBEEF0000);
    do_req(1'b0, 3'd1, 32'h22, 32'd0);
    check("lh_0x22", last_rdata, 32'hFFFFBEEF);
    do_req(1'b0, 3'd5, 32'h22, 32'd0);
    check("lhu_0x22", last_rdata, 32'h0000BEEF);

    do_req(1'b0, 3'd2, 32'h06, 32'd0);
    check("lw_misalign_err", {31'd0, last_err}, 32'd1);
    do_req(1'b1, 3'd1, 32'h03, 32'h1234);
    check("sh_misalign_err", {31'd0, last_err}, 32'd1);
    do_req(1'b0, 3'd3, 32'h00, 32'd0);
    do_req(1'b1, 3'd4, 32'h04, 32'h55);

    reset_mid_store();
    back_to_back();

    for (int k = 0; k < 150; k++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 1023));
      if ($urandom_range(0, 1) == 1) a = a & 32'hFFFF_FFFC;
      do_req(1'($urandom), 3'($urandom), a, $urandom);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
